// File: rtl/led_breathe.sv
// led_breathe: multi-channel PWM LED driver (off / on / breathe / blink) with a shared prescaler.
// Define LED_BREATHE_GAMMA_EN for a quadratic breathe ramp; otherwise duty equals level (linear).
module led_breathe #(
  parameter int NUM_LEDS      = 4,
  parameter int PRESCALE      = 1024,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 32
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic                                               en_i,
  input  logic                                               cfg_valid_i,
  output logic                                               cfg_ready_o,
  input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] cfg_led_i,
  input  logic [1:0]                                         cfg_mode_i,
  output logic [NUM_LEDS-1:0]                                led_o,
  output logic                                               period_o
);

  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_t;

  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BLK_W-1:0]    blink_cnt;
  logic                tick;
  logic                wrap;
  logic                blink_tc;

  logic                pend_valid;
  logic [LED_W-1:0]    pend_led;
  mode_t               pend_mode;
  logic                accept;
  logic [LED_W:0]      led_ext;
  logic                led_in_range;

  assign tick     = en_i && (prescaler == PRE_W'(PRESCALE - 1));
  assign wrap     = tick && (pwm_cnt == PWM_MAX);
  assign blink_tc = wrap && (blink_cnt == BLK_W'(BLINK_PERIODS - 1));

  assign accept       = cfg_valid_i && !pend_valid;
  assign led_ext      = {1'b0, cfg_led_i};
  assign led_in_range = led_ext < (LED_W + 1)'(NUM_LEDS);
  assign cfg_ready_o  = !pend_valid;

  // Shared timebase: everything freezes while en_i is low, so no wrap can occur then.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      period_o  <= 1'b0;
    end else begin
      period_o <= wrap;
      if (en_i) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          pwm_cnt <= pwm_cnt + 1'b1;
        end
        if (wrap) begin
          blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
        end
      end
    end
  end

  // Single pending slot. The slot only becomes visible the cycle after the accept,
  // so a wrap in the accept cycle cannot apply it; the next wrap does.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_led   <= '0;
      pend_mode  <= MODE_OFF;
    end else if (accept && led_in_range) begin
      pend_valid <= 1'b1;
      pend_led   <= cfg_led_i;
      pend_mode  <= mode_t'(cfg_mode_i);
    end else if (wrap && pend_valid) begin
      pend_valid <= 1'b0;
    end
  end

  for (genvar ch = 0; ch < NUM_LEDS; ch++) begin : g_ch
    localparam logic [LED_W-1:0] CH_IDX = LED_W'(ch);

    mode_t               mode;
    logic [PWM_BITS-1:0] level;
    logic                dir_down;
    logic                blink_state;
    logic [PWM_BITS-1:0] duty;
    logic                apply;
    logic                led_q;

    assign apply = wrap && pend_valid && (pend_led == CH_IDX);

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
    assign duty     = PWM_BITS'(level_sq >> PWM_BITS);
`else
    assign duty = level;
`endif

    // Channel state only moves on a wrap; a freshly applied mode restarts from level 0, rising.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mode        <= MODE_OFF;
        level       <= '0;
        dir_down    <= 1'b0;
        blink_state <= 1'b0;
      end else if (apply) begin
        mode        <= pend_mode;
        level       <= '0;
        dir_down    <= 1'b0;
        blink_state <= 1'b0;
      end else if (wrap) begin
        case (mode)
          MODE_BREATHE: begin
            if (!dir_down) begin
              if (level != PWM_MAX) begin
                level <= level + 1'b1;
              end
              if (level >= PWM_MAX - 1'b1) begin
                dir_down <= 1'b1;
              end
            end else begin
              if (level != '0) begin
                level <= level - 1'b1;
              end
              if (level <= PWM_BITS'(1)) begin
                dir_down <= 1'b0;
              end
            end
          end
          MODE_BLINK: begin
            if (blink_tc) begin
              blink_state <= ~blink_state;
            end
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        led_q <= 1'b0;
      end else if (!en_i) begin
        led_q <= 1'b0;
      end else begin
        case (mode)
          MODE_ON:      led_q <= 1'b1;
          MODE_BREATHE: led_q <= (pwm_cnt < duty);
          MODE_BLINK:   led_q <= blink_state;
          default:      led_q <= 1'b0;
        endcase
      end
    end

    assign led_o[ch] = led_q;
  end

endmodule

// File: tb/tb_led_breathe.sv
// tb_led_breathe: hand-derived vector table, directed corner sequences and a randomized
// run compared against an arithmetic model (honours LED_BREATHE_GAMMA_EN if defined).
module tb_led_breathe;

  localparam int N    = 4;
  localparam int P    = 2;
  localparam int B    = 4;
  localparam int BP   = 2;
  localparam int PER  = P * (1 << B);
  localparam int MAXL = (1 << B) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [1:0]   cfg_led = '0;
  logic [1:0]   cfg_mode = '0;
  logic         cfg_ready;
  logic [N-1:0] led;
  logic         period;

  logic         cfg_valid_b = 1'b0;
  logic [2:0]   cfg_led_b = '0;
  logic [1:0]   cfg_mode_b = '0;
  logic         cfg_ready_b;
  logic [4:0]   led_b;
  logic         period_b;

  int check_cnt = 0;
  int pass_cnt  = 0;

  led_breathe #(.NUM_LEDS(N), .PRESCALE(P), .PWM_BITS(B), .BLINK_PERIODS(BP)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_led_i(cfg_led), .cfg_mode_i(cfg_mode), .led_o(led), .period_o(period)
  );

  // A five-channel copy so an index beyond the channel count can actually be presented.
  led_breathe #(.NUM_LEDS(5), .PRESCALE(P), .PWM_BITS(B), .BLINK_PERIODS(BP)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_valid_i(cfg_valid_b), .cfg_ready_o(cfg_ready_b),
    .cfg_led_i(cfg_led_b), .cfg_mode_i(cfg_mode_b), .led_o(led_b), .period_o(period_b)
  );

  always #5 clk = ~clk;

  // Reference model: enabled clock count, wrap count and the wrap index at which each
  // channel's mode was applied; level and blink phase follow arithmetically from those.
  int           run;
  int           wraps;
  bit           pend;
  int           pend_led;
  int           pend_mode;
  int           mmode [N];
  int           base [N];
  logic [N-1:0] exp_led;
  logic         exp_period;
  logic         exp_ready;

  function automatic int tri_level(input int n);
    int t;
    t = n % (2 * MAXL);
    return (t <= MAXL) ? t : 2 * MAXL - t;
  endfunction

  function automatic int duty_of(input int lvl);
`ifdef LED_BREATHE_GAMMA_EN
    return (lvl * lvl) >> B;
`else
    return lvl;
`endif
  endfunction

  task automatic model_reset();
    run = 0;
    wraps = 0;
    pend = 1'b0;
    pend_led = 0;
    pend_mode = 0;
    for (int i = 0; i < N; i++) begin
      mmode[i] = 0;
      base[i] = 0;
    end
    exp_led = '0;
    exp_period = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic apply_stimulus(input bit e, input bit v, input int l, input int m);
    en = e;
    cfg_valid = v;
    cfg_led = 2'(l);
    cfg_mode = 2'(m);
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One clock edge: model outputs are derived from pre-edge state, then state advances.
  task automatic step();
    logic [N-1:0] nled;
    bit           w;
    bit           acc;
    int           pwm;
    int           li;
    w   = en && ((run % PER) == PER - 1);
    pwm = (run / P) % (1 << B);
    for (int ch = 0; ch < N; ch++) begin
      case (mmode[ch])
        1:       nled[ch] = 1'b1;
        2:       nled[ch] = pwm < duty_of(tri_level(wraps - base[ch]));
        3:       nled[ch] = (((wraps / BP) - (base[ch] / BP)) % 2) != 0;
        default: nled[ch] = 1'b0;
      endcase
      if (!en) nled[ch] = 1'b0;
    end
    acc = cfg_valid && !pend;
    li  = int'(cfg_led);
    @(posedge clk);
    if (w) begin
      wraps++;
      if (pend) begin
        mmode[pend_led] = pend_mode;
        base[pend_led]  = wraps;
        pend = 1'b0;
      end
    end
    if (acc && li < N) begin
      pend = 1'b1;
      pend_led = li;
      pend_mode = int'(cfg_mode);
    end
    if (en) run++;
    exp_led = nled;
    exp_period = w;
    exp_ready = !pend;
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
  endtask

  typedef struct {
    int cycles;
    bit en;
    bit valid;
    int led;
    int mode;
    int exp_led;
    bit exp_period;
    bit exp_ready;
  } vec_t;

  function automatic vec_t mk(input int c, input bit e, input bit v, input int l, input int m,
                              input int el, input bit ep, input bit er);
    vec_t r;
    r.cycles = c; r.en = e; r.valid = v; r.led = l; r.mode = m;
    r.exp_led = el; r.exp_period = ep; r.exp_ready = er;
    return r;
  endfunction

  vec_t vecs [20];

  initial begin
    int cnt;
    bit got;

    // Timeline from reset release; comments give the edge index reached at the end of each row.
    vecs[0]  = mk( 1, 1, 1, 2, 1, 'b0000, 0, 0);  // 1: accept led2 ON
    vecs[1]  = mk(30, 1, 0, 0, 0, 'b0000, 0, 0);  // 31
    vecs[2]  = mk( 1, 1, 0, 0, 0, 'b0000, 1, 1);  // 32: wrap applies ON
    vecs[3]  = mk( 1, 1, 0, 0, 0, 'b0100, 0, 1);  // 33: led lags mode by one
    vecs[4]  = mk( 1, 1, 1, 0, 2, 'b0100, 0, 0);  // 34: accept led0 BREATHE
    vecs[5]  = mk(29, 1, 0, 0, 0, 'b0100, 0, 0);  // 63
    vecs[6]  = mk( 1, 1, 0, 0, 0, 'b0100, 1, 1);  // 64: apply, level 0
    vecs[7]  = mk( 1, 1, 1, 3, 3, 'b0100, 0, 0);  // 65: accept led3 BLINK
    vecs[8]  = mk(31, 1, 0, 0, 0, 'b0100, 1, 1);  // 96: apply blink
    vecs[9]  = mk( 1, 1, 0, 0, 0, 'b0101, 0, 1);  // 97: level 1 -> 2 cycles high
    vecs[10] = mk( 2, 1, 0, 0, 0, 'b0100, 0, 1);  // 99
    vecs[11] = mk(30, 1, 0, 0, 0, 'b1101, 0, 1);  // 129: blink toggled, level 2
    vecs[12] = mk( 4, 1, 0, 0, 0, 'b1100, 0, 1);  // 133
    vecs[13] = mk(10, 0, 0, 0, 0, 'b0000, 0, 1);  // 143: disabled forces off
    vecs[14] = mk( 1, 1, 0, 0, 0, 'b1100, 0, 1);  // 144
    vecs[15] = mk(25, 1, 0, 0, 0, 'b1100, 0, 1);  // 169
    vecs[16] = mk( 1, 1, 1, 1, 1, 'b1100, 1, 0);  // 170: accept on a wrap
    vecs[17] = mk(31, 1, 0, 0, 0, 'b1100, 0, 0);  // 201: not yet applied
    vecs[18] = mk( 1, 1, 0, 0, 0, 'b1100, 1, 1);  // 202: applied one period later
    vecs[19] = mk( 1, 1, 0, 0, 0, 'b0111, 0, 1);  // 203

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset led", int'(led), 0);
    check_output("reset period", int'(period), 0);
    check_output("reset ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].valid, vecs[i].led, vecs[i].mode);
      step();
      if (vecs[i].valid) apply_stimulus(vecs[i].en, 1'b0, 0, 0);
      repeat (vecs[i].cycles - 1) step();
      check_output($sformatf("vec%0d led", i), int'(led), vecs[i].exp_led);
      check_output($sformatf("vec%0d period", i), int'(period), int'(vecs[i].exp_period));
      check_output($sformatf("vec%0d ready", i), int'(cfg_ready), int'(vecs[i].exp_ready));
    end

    // Reset in the middle of a pending update, without a clock edge.
    apply_stimulus(1, 1, 0, 1);
    step();
    apply_stimulus(1, 0, 0, 0);
    check_output("pending before reset", int'(cfg_ready), 0);
    async_reset();
    check_output("async reset led", int'(led), 0);
    check_output("async reset period", int'(period), 0);
    check_output("async reset ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 100) begin
      apply_stimulus(1, cnt == 0, 2, 1);
      step();
      cnt++;
      if (period) got = 1'b1;
    end
    check_output("first period after reset", got ? cnt : -1, 32);
    check_output("dut_b period aligned", int'(period_b), 1);
    apply_stimulus(1, 0, 0, 0);
    step();
    check_output("period width", int'(period), 0);
    check_output("ON applied", int'(led), 'b0100);

    cnt = 1;
    got = 1'b0;
    while (!got && cnt < 200) begin
      apply_stimulus(!(cnt >= 5 && cnt < 15), 0, 0, 0);
      step();
      cnt++;
      if (cnt == 15) check_output("disabled led", int'(led), 0);
      if (period) got = 1'b1;
    end
    check_output("period delayed by disable", got ? cnt : -1, 42);
    step();
    check_output("led after re-enable", int'(led), 'b0100);

    // Out-of-range index on the five-channel instance is dropped; index 4 is live.
    cfg_valid_b = 1'b1; cfg_led_b = 3'd5; cfg_mode_b = 2'd1;
    step();
    cfg_valid_b = 1'b0;
    check_output("bad index ready", int'(cfg_ready_b), 1);
    repeat (70) step();
    check_output("bad index led", int'(led_b), 0);
    cfg_valid_b = 1'b1; cfg_led_b = 3'd4; cfg_mode_b = 2'd1;
    step();
    cfg_valid_b = 1'b0;
    check_output("index4 accepted", int'(cfg_ready_b), 0);
    repeat (70) step();
    check_output("index4 led", int'(led_b), 'b10000);
    check_output("index4 ready back", int'(cfg_ready_b), 1);

    // Randomized traffic against the model.
    async_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      step();
      check_output($sformatf("random cycle %0d", i),
                   int'({led, period, cfg_ready}), int'({exp_led, exp_period, exp_ready}));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
